// File: rtl/clk_divisor_multi.sv
// NUM_CH independent programmable square-wave dividers with 1-cycle rise/fall ticks.
// New high/low lengths wait in per-channel shadow registers and are applied only at a period boundary.
module clk_divisor_multi #(
    parameter int          NUM_CH   = 4,
    parameter int          CH_SEL_W = 2,
    parameter int          CNT_W    = 32,
    parameter int unsigned DEF_HIGH = 25000000,
    parameter int unsigned DEF_LOW  = 25000000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                cfg_wr,
    input  logic [CH_SEL_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_low,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   clkout,
    output logic [NUM_CH-1:0]   rise_tick,
    output logic [NUM_CH-1:0]   fall_tick,
    output logic [NUM_CH-1:0]   upd_pending
);

    localparam logic [CNT_W-1:0] L_DEF_HIGH = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] L_DEF_LOW  = CNT_W'(DEF_LOW);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic w_cfg_ok;
    logic r_cfg_err;

    assign w_cfg_ok = (cfg_high != '0) && (cfg_low != '0) && (int'(cfg_ch) < NUM_CH);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && !w_cfg_ok;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_act_high;
        logic [CNT_W-1:0] r_act_low;
        logic [CNT_W-1:0] r_sh_high;
        logic [CNT_W-1:0] r_sh_low;
        logic             r_pend;
        logic             r_clk;
        logic             r_rise;
        logic             r_fall;
        logic             w_wr;
        logic             w_high_end;
        logic             w_low_end;
        logic             w_bnd;

        assign w_wr       = cfg_wr && w_cfg_ok && (int'(cfg_ch) == gi);
        assign w_high_end = (r_state == ST_HIGH) && (r_cnt == r_act_high - L_ONE);
        assign w_low_end  = (r_state == ST_LOW)  && (r_cnt == r_act_low - L_ONE);
        assign w_bnd      = w_low_end || ((r_state == ST_IDLE) && ch_en[gi]);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_act_high <= L_DEF_HIGH;
                r_act_low  <= L_DEF_LOW;
                r_sh_high  <= L_DEF_HIGH;
                r_sh_low   <= L_DEF_LOW;
                r_pend     <= 1'b0;
                r_clk      <= 1'b0;
                r_rise     <= 1'b0;
                r_fall     <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;

                if (w_bnd && r_pend) begin
                    r_act_high <= r_sh_high;
                    r_act_low  <= r_sh_low;
                    r_pend     <= 1'b0;
                end
                // A write on the boundary edge re-arms pend for the next period.
                if (w_wr) begin
                    r_sh_high <= cfg_high;
                    r_sh_low  <= cfg_low;
                    r_pend    <= 1'b1;
                end

                case (r_state)
                    ST_IDLE: begin
                        if (ch_en[gi]) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= '0;
                            r_clk   <= 1'b1;
                            r_rise  <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (w_high_end) begin
                            r_state <= ST_LOW;
                            r_cnt   <= '0;
                            r_clk   <= 1'b0;
                            r_fall  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + L_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (w_low_end) begin
                            r_cnt <= '0;
                            if (ch_en[gi]) begin
                                r_state <= ST_HIGH;
                                r_clk   <= 1'b1;
                                r_rise  <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + L_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_clk   <= 1'b0;
                    end
                endcase
            end
        end

        assign clkout[gi]      = r_clk;
        assign rise_tick[gi]   = r_rise;
        assign fall_tick[gi]   = r_fall;
        assign upd_pending[gi] = r_pend;
    end

endmodule

// File: tb/tb_clk_divisor_multi.sv
// Directed bench for clk_divisor_multi: per-cycle vector tables plus hand-written reset/error sequences.
module tb_clk_divisor_multi;

    localparam int NUM_CH   = 4;
    localparam int CH_SEL_W = 3;
    localparam int CNT_W    = 16;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b1;
    logic [NUM_CH-1:0]   ch_en = '0;
    logic                cfg_wr = 1'b0;
    logic [CH_SEL_W-1:0] cfg_ch = '0;
    logic [CNT_W-1:0]    cfg_high = '0;
    logic [CNT_W-1:0]    cfg_low = '0;
    logic                cfg_err;
    logic [NUM_CH-1:0]   clkout;
    logic [NUM_CH-1:0]   rise_tick;
    logic [NUM_CH-1:0]   fall_tick;
    logic [NUM_CH-1:0]   upd_pending;

    clk_divisor_multi #(
        .NUM_CH   (NUM_CH),
        .CH_SEL_W (CH_SEL_W),
        .CNT_W    (CNT_W),
        .DEF_HIGH (3),
        .DEF_LOW  (2)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .ch_en       (ch_en),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .cfg_err     (cfg_err),
        .clkout      (clkout),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .upd_pending (upd_pending)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0]  en;
        logic        wr;
        logic [2:0]  ch;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [3:0]  clk;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  pend;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [3:0] en, input logic wr, input logic [2:0] ch,
                                input logic [15:0] hi, input logic [15:0] lo,
                                input logic [3:0] clk, input logic [3:0] rise,
                                input logic [3:0] fall, input logic [3:0] pend);
        vec_t v;
        v.en = en; v.wr = wr; v.ch = ch; v.hi = hi; v.lo = lo;
        v.clk = clk; v.rise = rise; v.fall = fall; v.pend = pend;
        return v;
    endfunction

    // Shorthand for rows with no config write.
    function automatic vec_t rw(input logic [3:0] en, input logic [3:0] clk, input logic [3:0] rise,
                                input logic [3:0] fall, input logic [3:0] pend);
        return mk(en, 1'b0, 3'd0, 16'd0, 16'd0, clk, rise, fall, pend);
    endfunction

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Must be entered just after a rising edge; each row drives inputs, then checks after the next edge.
    task automatic run_rows(input string tag);
        foreach (vq[k]) begin
            ch_en    = vq[k].en;
            cfg_wr   = vq[k].wr;
            cfg_ch   = vq[k].ch;
            cfg_high = vq[k].hi;
            cfg_low  = vq[k].lo;
            @(posedge sys_clk);
            #1;
            check4($sformatf("%s[%0d] clkout", tag, k), clkout, vq[k].clk);
            check4($sformatf("%s[%0d] rise_tick", tag, k), rise_tick, vq[k].rise);
            check4($sformatf("%s[%0d] fall_tick", tag, k), fall_tick, vq[k].fall);
            check4($sformatf("%s[%0d] upd_pending", tag, k), upd_pending, vq[k].pend);
            check1($sformatf("%s[%0d] cfg_err", tag, k), cfg_err, 1'b0);
        end
        cfg_wr = 1'b0;
        vq.delete();
    endtask

    task automatic bad_wr(input string name, input logic [2:0] ch, input logic [15:0] hi,
                          input logic [15:0] lo);
        cfg_wr   = 1'b1;
        cfg_ch   = ch;
        cfg_high = hi;
        cfg_low  = lo;
        @(posedge sys_clk);
        #1;
        cfg_wr = 1'b0;
        check1({name, " cfg_err pulse"}, cfg_err, 1'b1);
        check4({name, " upd_pending"}, upd_pending, 4'b0000);
        @(posedge sys_clk);
        #1;
        check1({name, " cfg_err clears"}, cfg_err, 1'b0);
        check4({name, " upd_pending after"}, upd_pending, 4'b0000);
    endtask

    task automatic push_default_period(input logic [3:0] b);
        vq.push_back(rw(b, b, b, 4'b0, 4'b0));
        vq.push_back(rw(b, b, 4'b0, 4'b0, 4'b0));
        vq.push_back(rw(b, b, 4'b0, 4'b0, 4'b0));
        vq.push_back(rw(b, 4'b0, 4'b0, b, 4'b0));
        vq.push_back(rw(b, 4'b0, 4'b0, 4'b0, 4'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 sys_rst_n = 1'b0;
        #1;
        check4("reset clkout", clkout, 4'b0);
        check4("reset rise_tick", rise_tick, 4'b0);
        check4("reset upd_pending", upd_pending, 4'b0);
        check1("reset cfg_err", cfg_err, 1'b0);
        repeat (2) @(posedge sys_clk);
        #1;
        check4("reset held clkout", clkout, 4'b0);
        sys_rst_n = 1'b1;

        // Channel 0 runs 3/2 for two periods, then ch_en drops on the 2nd HIGH cycle of period 3.
        push_default_period(4'b0001);
        push_default_period(4'b0001);
        vq.push_back(rw(4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0));
        vq.push_back(rw(4'b0001, 4'b0001, 4'b0,    4'b0, 4'b0));
        vq.push_back(rw(4'b0000, 4'b0001, 4'b0,    4'b0, 4'b0));
        vq.push_back(rw(4'b0000, 4'b0000, 4'b0,    4'b0001, 4'b0));
        for (int i = 0; i < 5; i++) vq.push_back(rw(4'b0000, 4'b0, 4'b0, 4'b0, 4'b0));
        run_rows("ch0_run_disable");

        // Channel 1: 1/1 written mid-HIGH, applied at the end of the current 3/2 period.
        vq.push_back(rw(4'b0010, 4'b0010, 4'b0010, 4'b0, 4'b0));
        vq.push_back(mk(4'b0010, 1'b1, 3'd1, 16'd1, 16'd1, 4'b0010, 4'b0, 4'b0, 4'b0010));
        vq.push_back(rw(4'b0010, 4'b0010, 4'b0,    4'b0,    4'b0010));
        vq.push_back(rw(4'b0010, 4'b0000, 4'b0,    4'b0010, 4'b0010));
        vq.push_back(rw(4'b0010, 4'b0000, 4'b0,    4'b0,    4'b0010));
        vq.push_back(rw(4'b0010, 4'b0010, 4'b0010, 4'b0,    4'b0));
        vq.push_back(rw(4'b0010, 4'b0000, 4'b0,    4'b0010, 4'b0));
        vq.push_back(rw(4'b0010, 4'b0010, 4'b0010, 4'b0,    4'b0));
        vq.push_back(rw(4'b0010, 4'b0000, 4'b0,    4'b0010, 4'b0));
        vq.push_back(rw(4'b0000, 4'b0000, 4'b0,    4'b0,    4'b0));
        vq.push_back(rw(4'b0000, 4'b0000, 4'b0,    4'b0,    4'b0));
        run_rows("ch1_update");

        bad_wr("bad_high0", 3'd0, 16'd0, 16'd5);
        bad_wr("bad_ch5",   3'd5, 16'd2, 16'd2);
        bad_wr("bad_low0",  3'd2, 16'd2, 16'd0);

        // Channel 2: pending 2/2, then 4/4 written exactly on the boundary edge.
        vq.push_back(rw(4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0));
        vq.push_back(mk(4'b0100, 1'b1, 3'd2, 16'd2, 16'd2, 4'b0100, 4'b0, 4'b0, 4'b0100));
        vq.push_back(rw(4'b0100, 4'b0100, 4'b0, 4'b0,    4'b0100));
        vq.push_back(rw(4'b0100, 4'b0000, 4'b0, 4'b0100, 4'b0100));
        vq.push_back(rw(4'b0100, 4'b0000, 4'b0, 4'b0,    4'b0100));
        vq.push_back(mk(4'b0100, 1'b1, 3'd2, 16'd4, 16'd4, 4'b0100, 4'b0100, 4'b0, 4'b0100));
        vq.push_back(rw(4'b0100, 4'b0100, 4'b0,    4'b0,    4'b0100));
        vq.push_back(rw(4'b0100, 4'b0000, 4'b0,    4'b0100, 4'b0100));
        vq.push_back(rw(4'b0100, 4'b0000, 4'b0,    4'b0,    4'b0100));
        vq.push_back(rw(4'b0100, 4'b0100, 4'b0100, 4'b0,    4'b0));
        for (int i = 0; i < 3; i++) vq.push_back(rw(4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0));
        vq.push_back(rw(4'b0100, 4'b0000, 4'b0, 4'b0100, 4'b0));
        for (int i = 0; i < 3; i++) vq.push_back(rw(4'b0100, 4'b0000, 4'b0, 4'b0, 4'b0));
        vq.push_back(rw(4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0));
        vq.push_back(mk(4'b0100, 1'b1, 3'd3, 16'd5, 16'd5, 4'b0100, 4'b0, 4'b0, 4'b1000));
        run_rows("ch2_boundary_wr");

        // Asynchronous reset mid-HIGH, away from any clock edge.
        ch_en = 4'b0000;
        #3 sys_rst_n = 1'b0;
        #1;
        check4("async_rst clkout", clkout, 4'b0);
        check4("async_rst rise_tick", rise_tick, 4'b0);
        check4("async_rst fall_tick", fall_tick, 4'b0);
        check4("async_rst upd_pending", upd_pending, 4'b0);
        check1("async_rst cfg_err", cfg_err, 1'b0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        push_default_period(4'b0100);
        push_default_period(4'b0100);
        run_rows("after_rst_defaults");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
